booth_ctrl: RTL and testbench
=============================

# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier datapath. It accepts a multiply request over a valid/ready handshake and loads the operand registers. It then runs N evaluate/shift iterations by inspecting the Booth bit pair {Q0, Q-1}, strobes the final-product register's load, and holds a result-valid flag until the consumer accepts. It has no arithmetic of its own: it drives the accumulator, shifter and product-register enables.

## Interface
- N, default 16: operand width (multiplier iterations); the product width is 2N.
- CNT_W, default 5: iteration-counter width, equal to $clog2(N)+1.

- clk, input, 1: clock, rising edge.
- reset, input, 1: synchronous, active-high.
- start_valid, input, 1: request to multiply the operands currently presented to the datapath.
- start_ready, output, 1: controller idle and able to accept a request.
- q_pair, input, 2: {Q0, Q-1}, taken from the datapath shift register.
- ld_operands, output, 1: load M and Q, and clear Q-1.
- clr_acc, output, 1: clear accumulator A.
- acc_en, output, 1: write A with A±M this cycle.
- add_sub, output, 1: 0 means A+M, 1 means A−M; valid only when acc_en=1, otherwise 0.
- shift_en, output, 1: arithmetic right shift of {A,Q,Q-1}.
- ld_product, output, 1: load the final-product register (it takes the upper 2N bits of the 2N+1 partial product).
- done_valid, output, 1: product register holds a new result.
- done_ready, input, 1: consumer accepts the result.
- busy, output, 1: asserted in every state except IDLE.
- iter_count, output, CNT_W: remaining iterations.

## Operation
- States: IDLE, LOAD, EVAL, SHIFT, FINISH, DONE.
- IDLE: start_ready=1. On start_valid&start_ready, go to LOAD.
- LOAD (1 cycle): ld_operands=1 and clr_acc=1; iter_count<=N; go to EVAL.
- EVAL (1 cycle), decoded from q_pair:
  - 01: acc_en=1, add_sub=0.
  - 10: acc_en=1, add_sub=1.
  - 00 or 11: acc_en=0.
  - Then go to SHIFT.
- SHIFT (1 cycle): shift_en=1; iter_count<=iter_count−1. If iter_count==1, go to FINISH; otherwise go to EVAL.
- FINISH (1 cycle): ld_product=1; go to DONE.
- DONE: done_valid=1. On done_ready, go to IDLE. The next request is accepted in the IDLE cycle that follows.
- Strobe decoding:
  - All strobes are decoded from the registered state.
  - acc_en and add_sub additionally depend on q_pair, and only in EVAL.
  - In any other state every strobe is 0.
  - At most one of {ld_operands, acc_en, shift_en, ld_product} is asserted in any cycle, except that clr_acc accompanies ld_operands.
- start_valid outside IDLE is ignored (start_ready=0). A request is not queued.
- done_ready outside DONE is ignored.
- iter_count holds its value outside LOAD and SHIFT. It never wraps below 0.

## Timing
- Reset:
  - On the next edge: state=IDLE, iter_count=0, all strobes 0, done_valid=0, busy=0.
  - start_ready=0 during every cycle in which reset is asserted.
  - Reset asserted mid-operation aborts the operation. No ld_product is issued, and the product register keeps its old value.
- Latency, with the handshake accepted at edge 0:
  - LOAD occupies cycle 1.
  - EVAL and SHIFT alternate over cycles 2..2N+1: N EVAL cycles, then N shift_en pulses.
  - FINISH (ld_product) is cycle 2N+2.
  - done_valid is first high in cycle 2N+3.
  - For N=16: ld_product in cycle 34, done_valid from cycle 35.
- Minimum request-to-request spacing is 2N+4 cycles, reached when done_ready is high on the first DONE cycle.
- done_valid stays high, unchanged, while done_ready=0, for any duration.
- Simultaneous reset and start_valid: reset wins, and the request is dropped.

## Test plan
- Reset: assert reset for 2 cycles with start_valid=1 → start_ready=0, busy=0, done_valid=0, all strobes 0, iter_count=0; after release, start_ready=1.
- Zero Booth activity: q_pair held 00, one request → no acc_en pulse, exactly 16 shift_en pulses, iter_count counts 16→0, ld_product only in cycle 34, done_valid from cycle 35.
- Decode: drive q_pair=01 in iterations 1 and 10 and q_pair=10 in iteration 2 → acc_en with add_sub=0, 0 and 1 respectively in those EVAL cycles, and acc_en=0 in all other EVAL cycles.
- Full datapath: M=7, Q=−3 with the datapath model attached → product register = 0xFFFFFFEB (−21) once done_valid is high; also −32768×−32768 → 0x40000000.
- Backpressure: hold done_ready=0 for 5 cycles and pulse start_valid during them → done_valid stays 1, start_ready stays 0, no LOAD; raising done_ready returns the controller to IDLE on the next edge.
- Abort and back-to-back: assert reset in cycle 10 → IDLE next edge, no ld_product; then issue two requests with done_ready tied high → second LOAD occurs exactly 2N+4 cycles after the first.

Source files
------------

// File: rtl/booth_ctrl_if.sv
// booth_ctrl_if: request/result handshake plus the datapath control bundle
// exchanged between the Booth sequencing controller and its surroundings.
// The slave modport is the controller; the master modport is the requester
// together with the datapath that feeds back the Booth bit pair.
interface booth_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start_valid;
  logic             start_ready;
  logic [1:0]       q_pair;
  logic             ld_operands;
  logic             clr_acc;
  logic             acc_en;
  logic             add_sub;
  logic             shift_en;
  logic             ld_product;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
  logic [CNT_W-1:0] iter_count;

  modport slave (
    input  start_valid, q_pair, done_ready,
    output start_ready, ld_operands, clr_acc, acc_en, add_sub, shift_en,
           ld_product, done_valid, busy, iter_count
  );

  modport master (
    output start_valid, q_pair, done_ready,
    input  start_ready, ld_operands, clr_acc, acc_en, add_sub, shift_en,
           ld_product, done_valid, busy, iter_count
  );
endinterface

// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller for a radix-2 Booth multiplier datapath.
// Accepts a request, loads operands, alternates N evaluate/shift iterations
// driven by the Booth pair {Q0, Q-1}, strobes the product register and holds
// a result-valid flag until the consumer accepts. All strobes are decoded
// from the registered state; only acc_en/add_sub look at q_pair, in EVAL.
module booth_ctrl #(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        reset,
  booth_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_EVAL   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Booth recoding of {Q0, Q-1}: returns {acc_en, add_sub}.
  // 01 -> add M, 10 -> subtract M, 00/11 -> no accumulator write.
  function automatic logic [1:0] booth_decode(input logic [1:0] pair);
    logic [1:0] res;
    case (pair)
      2'b01:   res = 2'b10;
      2'b10:   res = 2'b11;
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       state_nxt_s;
  logic [CNT_W-1:0] iter_r;
  logic [CNT_W-1:0] iter_nxt_s;
  logic [1:0]       booth_s;

  // Next-state and iteration-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    iter_nxt_s  = iter_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start_valid) begin
          state_nxt_s = S_LOAD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        iter_nxt_s  = CNT_N;
        state_nxt_s = S_EVAL;
      end
      S_EVAL: begin
        state_nxt_s = S_SHIFT;
      end
      S_SHIFT: begin
        // Saturating decrement: the counter never wraps below zero.
        if (iter_r != CNT_ZERO) begin
          iter_nxt_s = iter_r - CNT_ONE;
        end else begin
          iter_nxt_s = CNT_ZERO;
        end
        // A corrupted zero count also exits instead of looping forever.
        if (iter_r <= CNT_ONE) begin
          state_nxt_s = S_FINISH;
        end else begin
          state_nxt_s = S_EVAL;
        end
      end
      S_FINISH: begin
        state_nxt_s = S_DONE;
      end
      S_DONE: begin
        if (bus.done_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        iter_nxt_s  = CNT_ZERO;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
      iter_r  <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      iter_r  <= iter_nxt_s;
    end
  end

  // Booth pair decode, only meaningful while in EVAL.
  always_comb begin
    booth_s = booth_decode(bus.q_pair);
  end

  // Datapath strobes; held low while reset is asserted so an abort never
  // issues a write (in particular no late ld_product).
  always_comb begin
    bus.ld_operands = 1'b0;
    bus.clr_acc     = 1'b0;
    bus.acc_en      = 1'b0;
    bus.add_sub     = 1'b0;
    bus.shift_en    = 1'b0;
    bus.ld_product  = 1'b0;
    if (reset) begin
      bus.ld_operands = 1'b0;
    end else begin
      case (state_r)
        S_LOAD: begin
          bus.ld_operands = 1'b1;
          bus.clr_acc     = 1'b1;
        end
        S_EVAL: begin
          bus.acc_en  = booth_s[1];
          bus.add_sub = booth_s[0];
        end
        S_SHIFT: begin
          bus.shift_en = 1'b1;
        end
        S_FINISH: begin
          bus.ld_product = 1'b1;
        end
        default: begin
          bus.ld_operands = 1'b0;
        end
      endcase
    end
  end

  // Handshake and status flags.
  always_comb begin
    bus.start_ready = (state_r == S_IDLE) && !reset;
    bus.done_valid  = (state_r == S_DONE);
    bus.busy        = (state_r != S_IDLE);
    bus.iter_count  = iter_r;
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: randomized self-checking bench for booth_ctrl. A behavioural
// datapath (accumulator with a guard bit, shift register, product register)
// is attached to the strobes; expectations come from the cycle timeline of a
// request, the Booth recoding of the multiplier bits and plain signed
// multiplication.
module tb_booth_ctrl;
  localparam int N     = 16;
  localparam int CNT_W = 5;
  // Observed vector layout:
  // {start_ready, busy, done_valid, ld_operands, clr_acc, acc_en, add_sub, shift_en, ld_product}
  localparam logic [8:0] V_IDLE = 9'b100000000;
  localparam logic [8:0] V_DONE = 9'b011000000;
  localparam logic [8:0] V_RST  = 9'b000000000;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  booth_ctrl_if #(.CNT_W(CNT_W)) bif ();

  booth_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic             use_dp   = 1'b0;
  logic [1:0]       forced_q = 2'b00;
  logic [N-1:0]     m_in     = '0;
  logic [N-1:0]     q_in     = '0;
  logic [1:0]       pat [0:N];

  // behavioural datapath; the extra accumulator bit covers M = -2^(N-1)
  logic [N:0]       acc;
  logic [N-1:0]     mr;
  logic [N-1:0]     qr;
  logic             q1;
  logic [2*N-1:0]   prod;

  int  prev_load   = 0;
  int  prev_hold   = 0;
  bit  prev_ok     = 1'b0;

  logic [8:0] obs_vec;
  assign obs_vec = {bif.start_ready, bif.busy, bif.done_valid, bif.ld_operands,
                    bif.clr_acc, bif.acc_en, bif.add_sub, bif.shift_en, bif.ld_product};
  assign bif.q_pair = use_dp ? {qr[0], q1} : forced_q;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bif.ld_operands) begin
      mr <= m_in;
      qr <= q_in;
      q1 <= 1'b0;
    end
    if (bif.clr_acc) acc <= '0;
    if (bif.acc_en) acc <= bif.add_sub ? acc - {mr[N-1], mr} : acc + {mr[N-1], mr};
    if (bif.shift_en) {acc, qr, q1} <= {acc[N], acc, qr};
    if (bif.ld_product) prod <= {acc[N-1:0], qr};
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs in cycle c of a request (c=1 is the LOAD cycle).
  function automatic logic [8:0] exp_run(input int c, input logic [1:0] p);
    logic [8:0] v;
    v = 9'b010000000;
    if (c == 1) begin
      v[5] = 1'b1;
      v[4] = 1'b1;
    end else if ((c % 2 == 0) && (c <= 2*N)) begin
      if (p == 2'b01) v[3] = 1'b1;
      else if (p == 2'b10) begin
        v[3] = 1'b1;
        v[2] = 1'b1;
      end
    end else if (c <= 2*N + 1) begin
      v[1] = 1'b1;
    end else begin
      v[0] = 1'b1;
    end
    return v;
  endfunction

  function automatic int exp_iter(input int c);
    return (c == 1) ? 0 : N - (c - 2) / 2;
  endfunction

  // One full request, entered and left in an IDLE cycle.
  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q,
                        input bit dp, input int hold);
    logic signed [N-1:0]   ms;
    logic signed [N-1:0]   qs;
    logic signed [2*N-1:0] ep;
    int load_cyc;
    ms = m;
    qs = q;
    ep = ms * qs;
    if (dp) begin
      for (int k = 1; k <= N; k++)
        pat[k] = {q[k-1], (k >= 2) ? q[k-2] : 1'b0};
    end
    m_in = m;
    q_in = q;
    use_dp = dp;
    bif.start_valid = 1'b1;
    bif.done_ready  = 1'b0;
    #1;
    check_eq("accept_ready", {63'd0, bif.start_ready}, 64'd1);
    @(posedge clk);
    #1;
    for (int c = 1; c <= 2*N + 2; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      bif.start_valid = 1'($urandom);
      bif.done_ready  = 1'($urandom);
      if ((c % 2 == 0) && (c <= 2*N)) forced_q = pat[c/2];
      else forced_q = 2'($urandom);
      #1;
      if (c == 1) load_cyc = cyc;
      check_eq($sformatf("strobes_c%0d", c), {55'd0, obs_vec},
               {55'd0, exp_run(c, (c % 2 == 0 && c <= 2*N) ? pat[c/2] : 2'b00)});
      check_eq($sformatf("iter_c%0d", c), {59'd0, bif.iter_count}, 64'(exp_iter(c)));
    end
    if (prev_ok)
      check_eq("req_spacing", 64'(load_cyc - prev_load), 64'(2*N + 4 + prev_hold));
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk);
      #1;
      bif.done_ready  = (h == hold);
      bif.start_valid = (h < hold) ? 1'($urandom) : 1'b0;
      forced_q = 2'($urandom);
      #1;
      check_eq($sformatf("done_h%0d", h), {55'd0, obs_vec}, {55'd0, V_DONE});
      check_eq("done_iter", {59'd0, bif.iter_count}, 64'd0);
      if (dp && (h == 0 || h == hold))
        check_eq($sformatf("product_%0h_x_%0h", m, q), {32'd0, prod}, {32'd0, ep});
    end
    @(posedge clk);
    #1;
    bif.done_ready  = 1'b0;
    bif.start_valid = 1'b0;
    #1;
    check_eq("back_to_idle", {55'd0, obs_vec}, {55'd0, V_IDLE});
    prev_load = load_cyc;
    prev_hold = hold;
    prev_ok   = 1'b1;
  endtask

  // Start a request and abort it with reset in cycle 10.
  task automatic run_abort();
    logic [2*N-1:0] p_before;
    p_before = prod;
    m_in = 16'h1234;
    q_in = 16'h0F0F;
    use_dp = 1'b1;
    bif.start_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    bif.start_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    bif.start_valid = 1'b1;
    #1;
    check_eq("abort_ready_low", {63'd0, bif.start_ready}, 64'd0);
    check_eq("abort_no_strobe", {55'd0, obs_vec}, {55'd0, 9'b010000000});
    @(posedge clk);
    #1;
    reset = 1'b0;
    bif.start_valid = 1'b0;
    #1;
    check_eq("abort_idle", {55'd0, obs_vec}, {55'd0, V_IDLE});
    check_eq("abort_iter", {59'd0, bif.iter_count}, 64'd0);
    repeat (2*N + 4) @(posedge clk);
    #2;
    check_eq("abort_prod_kept", {32'd0, prod}, {32'd0, p_before});
    check_eq("abort_still_idle", {55'd0, obs_vec}, {55'd0, V_IDLE});
    prev_ok = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rm;
    logic [N-1:0] rq;
    bit rdp;
    bif.start_valid = 1'b1;
    bif.done_ready  = 1'b0;
    reset = 1'b1;
    for (int k = 0; k <= N; k++) pat[k] = 2'b00;

    // reset held for two cycles with a pending request
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #2;
      check_eq($sformatf("reset_c%0d", i), {55'd0, obs_vec}, {55'd0, V_RST});
      check_eq("reset_iter", {59'd0, bif.iter_count}, 64'd0);
    end
    reset = 1'b0;
    bif.start_valid = 1'b0;
    #1;
    check_eq("post_reset_ready", {55'd0, obs_vec}, {55'd0, V_IDLE});

    // no Booth activity
    for (int k = 1; k <= N; k++) pat[k] = 2'b00;
    run_op(16'h0000, 16'h0000, 1'b0, 0);

    // decode: add in iterations 1 and 10, subtract in iteration 2
    for (int k = 1; k <= N; k++) pat[k] = 2'b00;
    pat[1]  = 2'b01;
    pat[10] = 2'b01;
    pat[2]  = 2'b10;
    run_op(16'h0000, 16'h0000, 1'b0, 0);

    // full datapath, including the most negative operands with backpressure
    run_op(16'd7, 16'hFFFD, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b1, 5);

    // abort, then back-to-back requests
    run_abort();
    run_op(16'h7FFF, 16'h8000, 1'b1, 0);
    run_op(16'hFFFF, 16'h7FFF, 1'b1, 0);

    // randomized requests
    for (int t = 0; t < 24; t++) begin
      rm  = 16'($urandom);
      rq  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rm = 16'h8000;
      if ($urandom_range(0, 7) == 0) rq = 16'h8000;
      rdp = ($urandom_range(0, 3) != 0);
      if (!rdp)
        for (int k = 1; k <= N; k++) pat[k] = 2'($urandom);
      run_op(rm, rq, rdp, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
